pc_gen_ds: RTL and testbench



---
 rtl/pc_gen_ds.sv | 121 ++++++++++++
 tb/tb_pc_gen_ds.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pc_gen_ds.sv
// Fetch-stage program counter with a configurable number of delay slots,
// exception redirect, and stall-safe slot counting.
module pc_gen_ds #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_ADDR  = XLEN'(32'h0000_3000),
  parameter logic [XLEN-1:0] EXC_ADDR    = XLEN'(32'h0000_4180),
  parameter int unsigned     DELAY_SLOTS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            En,
  input  logic            IsJBrD,
  input  logic [XLEN-1:0] NPCD,
  input  logic            ExcReq,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic            PendingF,
  output logic            InSlotF,
  output logic            BrInSlotErr
);

  localparam int unsigned     CNT_W  = 3;
  localparam logic [CNT_W-1:0] R_INIT = CNT_W'(DELAY_SLOTS - 1);
  localparam logic [XLEN-1:0]  FOUR   = XLEN'(4);

  if (DELAY_SLOTS < 1 || DELAY_SLOTS > 4) begin : g_bad_delay_slots
    $error("pc_gen_ds: DELAY_SLOTS must be in 1..4");
  end

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc4_q, pc4_d;
  logic [XLEN-1:0]  tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             slot_q, slot_d;
  logic             err_q, err_d;

  logic             capture;
  logic [CNT_W-1:0] remain;
  logic [XLEN-1:0]  target;

  // A redirect is in flight either from an earlier capture or from this cycle's J/Br.
  assign capture = IsJBrD & ~pend_q;
  assign remain  = pend_q ? cnt_q : R_INIT;
  assign target  = pend_q ? tgt_q : NPCD;

  always_comb begin
    pc_d   = pc_q;
    pc4_d  = pc4_q;
    tgt_d  = tgt_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    slot_d = slot_q;
    err_d  = 1'b0;

    if (ExcReq) begin
      pc_d   = EXC_ADDR;
      pc4_d  = EXC_ADDR + FOUR;
      cnt_d  = '0;
      pend_d = 1'b0;
      slot_d = 1'b0;
    end else begin
      err_d = IsJBrD & pend_q;
      if (capture) begin
        tgt_d = NPCD;
      end
      if (pend_q || capture) begin
        if (En) begin
          if (remain == '0) begin
            pc_d   = target;
            pc4_d  = target + FOUR;
            cnt_d  = '0;
            pend_d = 1'b0;
            slot_d = 1'b0;
          end else begin
            pc_d   = pc4_q;
            pc4_d  = pc4_q + FOUR;
            cnt_d  = remain - CNT_W'(1);
            pend_d = 1'b1;
            slot_d = 1'b1;
          end
        end else begin
          // Stalled: keep the request and do not burn a slot.
          cnt_d  = remain;
          pend_d = 1'b1;
          slot_d = 1'b1;
        end
      end else if (En) begin
        pc_d  = pc4_q;
        pc4_d = pc4_q + FOUR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_ADDR;
      pc4_q  <= RESET_ADDR + FOUR;
      tgt_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      slot_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      pc4_q  <= pc4_d;
      tgt_q  <= tgt_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      slot_q <= slot_d;
      err_q  <= err_d;
    end
  end

  assign PCF         = pc_q;
  assign PCPlus4F    = pc4_q;
  assign PendingF    = pend_q;
  assign InSlotF     = slot_q;
  assign BrInSlotErr = err_q;

endmodule

// File: tb/tb_pc_gen_ds.sv
// Directed bench for pc_gen_ds: three instances (1, 2, 3 delay slots) driven
// from a vector table plus a mid-cycle reset sequence.
module tb_pc_gen_ds;

  logic        clk = 1'b0;
  logic        rst;
  logic        en  [1:3];
  logic        jb  [1:3];
  logic        exc [1:3];
  logic [31:0] npc [1:3];
  logic [31:0] pcf [1:3];
  logic [31:0] pc4 [1:3];
  logic        pend[1:3];
  logic        slot[1:3];
  logic        err [1:3];

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  pc_gen_ds #(.DELAY_SLOTS(1)) u_ds1 (
    .clk(clk), .rst(rst), .En(en[1]), .IsJBrD(jb[1]), .NPCD(npc[1]), .ExcReq(exc[1]),
    .PCF(pcf[1]), .PCPlus4F(pc4[1]), .PendingF(pend[1]), .InSlotF(slot[1]), .BrInSlotErr(err[1]));
  pc_gen_ds #(.DELAY_SLOTS(2)) u_ds2 (
    .clk(clk), .rst(rst), .En(en[2]), .IsJBrD(jb[2]), .NPCD(npc[2]), .ExcReq(exc[2]),
    .PCF(pcf[2]), .PCPlus4F(pc4[2]), .PendingF(pend[2]), .InSlotF(slot[2]), .BrInSlotErr(err[2]));
  pc_gen_ds #(.DELAY_SLOTS(3)) u_ds3 (
    .clk(clk), .rst(rst), .En(en[3]), .IsJBrD(jb[3]), .NPCD(npc[3]), .ExcReq(exc[3]),
    .PCF(pcf[3]), .PCPlus4F(pc4[3]), .PendingF(pend[3]), .InSlotF(slot[3]), .BrInSlotErr(err[3]));

  typedef struct {
    int          d;
    logic        en;
    logic        jb;
    logic        exc;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        pend;
    logic        slot;
    logic        err;
  } vec_t;

  vec_t vecs[40];
  int   nvec = 0;

  task automatic add(input int d, input logic e, input logic j, input logic x,
                     input logic [31:0] n, input logic [31:0] p,
                     input logic pd, input logic s, input logic er);
    vecs[nvec] = '{d, e, j, x, n, p, pd, s, er};
    nvec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int d, input logic [31:0] p,
                         input logic pd, input logic s, input logic er);
    chk({tag, " PCF"},         pcf[d], p);
    chk({tag, " PCPlus4F"},    pc4[d], p + 32'd4);
    chk({tag, " PendingF"},    32'(pend[d]), 32'(pd));
    chk({tag, " InSlotF"},     32'(slot[d]), 32'(s));
    chk({tag, " BrInSlotErr"}, 32'(err[d]), 32'(er));
  endtask

  task automatic idle_inputs();
    for (int k = 1; k <= 3; k++) begin
      en[k] = 1'b0; jb[k] = 1'b0; exc[k] = 1'b0; npc[k] = 32'h0;
    end
  endtask

  initial begin
    // DS=1: sequential fetch, 1-cycle redirect, wrap, stalled capture
    add(1, 1,0,0, 32'h0,        32'h3004, 0,0,0);
    add(1, 1,0,0, 32'h0,        32'h3008, 0,0,0);
    add(1, 1,0,0, 32'h0,        32'h300C, 0,0,0);
    add(1, 1,1,0, 32'h3100,     32'h3100, 0,0,0);
    add(1, 1,0,0, 32'h0,        32'h3104, 0,0,0);
    add(1, 1,1,0, 32'hFFFFFFFC, 32'hFFFFFFFC, 0,0,0);
    add(1, 1,0,0, 32'h0,        32'h00000000, 0,0,0);
    add(1, 0,1,0, 32'h6000,     32'h00000000, 1,1,0);
    add(1, 1,0,0, 32'h0,        32'h6000, 0,0,0);
    // DS=3: three slots, then exception kills a pending redirect
    add(3, 1,0,0, 32'h0,    32'h3004, 0,0,0);
    add(3, 1,0,0, 32'h0,    32'h3008, 0,0,0);
    add(3, 1,0,0, 32'h0,    32'h300C, 0,0,0);
    add(3, 1,1,0, 32'h3100, 32'h3010, 1,1,0);
    add(3, 1,0,0, 32'h0,    32'h3014, 1,1,0);
    add(3, 1,0,0, 32'h0,    32'h3100, 0,0,0);
    add(3, 1,1,0, 32'h3200, 32'h3104, 1,1,0);
    add(3, 0,0,1, 32'h0,    32'h4180, 0,0,0);
    add(3, 1,0,0, 32'h0,    32'h4184, 0,0,0);
    add(3, 1,0,0, 32'h0,    32'h4188, 0,0,0);
    add(3, 1,1,1, 32'h5000, 32'h4180, 0,0,0);
    add(3, 1,0,0, 32'h0,    32'h4184, 0,0,0);
    // DS=2: stalled capture, then J/Br while pending
    add(2, 1,0,0, 32'h0,    32'h3004, 0,0,0);
    add(2, 1,0,0, 32'h0,    32'h3008, 0,0,0);
    add(2, 1,0,0, 32'h0,    32'h300C, 0,0,0);
    add(2, 0,1,0, 32'h3100, 32'h300C, 1,1,0);
    add(2, 0,0,0, 32'h0,    32'h300C, 1,1,0);
    add(2, 0,0,0, 32'h0,    32'h300C, 1,1,0);
    add(2, 1,0,0, 32'h0,    32'h3010, 1,1,0);
    add(2, 1,0,0, 32'h0,    32'h3100, 0,0,0);
    add(2, 1,1,0, 32'h3200, 32'h3104, 1,1,0);
    add(2, 0,1,0, 32'h5000, 32'h3104, 1,1,1);
    add(2, 0,0,0, 32'h0,    32'h3104, 1,1,0);
    add(2, 1,0,0, 32'h0,    32'h3200, 0,0,0);
    add(2, 0,1,0, 32'h7000, 32'h3200, 1,1,0);

    idle_inputs();
    rst = 1'b1;
    #12;
    for (int k = 1; k <= 3; k++) chk_all($sformatf("reset ds%0d", k), k, 32'h3000, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      @(negedge clk);
      idle_inputs();
      en[vecs[i].d]  = vecs[i].en;
      jb[vecs[i].d]  = vecs[i].jb;
      exc[vecs[i].d] = vecs[i].exc;
      npc[vecs[i].d] = vecs[i].npc;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d ds%0d", i, vecs[i].d), vecs[i].d,
              vecs[i].pc, vecs[i].pend, vecs[i].slot, vecs[i].err);
    end

    // Mid-cycle asynchronous reset while ds2 has a redirect pending
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all("async rst ds2", 2, 32'h3000, 0, 0, 0);
    chk_all("async rst ds1", 1, 32'h3000, 0, 0, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    en[2] = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post rst ds2", 2, 32'h3004, 0, 0, 0);
    @(negedge clk);
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
